operand_fetch: RTL and testbench

Issue-side client of the 32×32 MIPS register file. Accepts decoded instructions over a valid/ready handshake and reads both source operands through the register file's two combinational read ports. A 32-bit scoreboard blocks RAW/WAW hazards against in-flight results, and writeback data is bypassed into the operand latch. The block is also the sole writer of the register file: it drives `regwrite`, `write_3` and `write_data_p3` from the writeback bus, so it sits between decode, execute and the register file.

---
 rtl/operand_fetch_if.sv | 26 ++
 rtl/operand_fetch.sv | 108 ++++++++++
 tb/tb_operand_fetch.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_if.sv
// Issue-side handshake and operand bundle between decode, operand_fetch and execute.
interface operand_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic        in_wen;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [4:0]  out_rd;
    logic        out_wen;

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_wen, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_rd, out_wen
    );

    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_wen, out_ready,
        output in_ready, out_valid, out_a, out_b, out_rd, out_wen
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: scoreboarded issue against the 32x32 register file, with writeback
// bypass into the operand latch; also the sole writer of the register file.
module operand_fetch #(
    parameter bit BYPASS = 1'b1
) (
    input  logic                reg_clk,
    input  logic                reg_rst,
    operand_fetch_if.slave      bus,
    output logic [4:0]          read_1,
    output logic [4:0]          read_2,
    input  logic [31:0]         read_data_p1,
    input  logic [31:0]         read_data_p2,
    output logic                regwrite,
    output logic [4:0]          write_3,
    output logic [31:0]         write_data_p3,
    input  logic                wb_valid,
    input  logic [4:0]          wb_rd,
    input  logic [31:0]         wb_data,
    output logic                wb_err
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned NREG = 32;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            out_valid_q;
    logic [XLEN-1:0] out_a_q;
    logic [XLEN-1:0] out_b_q;
    logic [RW-1:0]   out_rd_q;
    logic            out_wen_q;

    logic            hit_rs;
    logic            hit_rt;
    logic            hit_rd;
    logic            avail_rs;
    logic            avail_rt;
    logic            dst_wr;
    logic            waw_ok;
    logic            in_ready_c;
    logic            issue;
    logic [XLEN-1:0] opnd_a;
    logic [XLEN-1:0] opnd_b;

    assign read_1        = bus.in_rs;
    assign read_2        = bus.in_rt;
    assign regwrite      = wb_valid && (wb_rd != RW'(0));
    assign write_3       = wb_rd;
    assign write_data_p3 = wb_data;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_wen   = out_wen_q;

    // Hazard check, bypass select and next scoreboard; set beats clear on the same register.
    always_comb begin
        hit_rs     = wb_valid && (wb_rd == bus.in_rs) && (bus.in_rs != RW'(0));
        hit_rt     = wb_valid && (wb_rd == bus.in_rt) && (bus.in_rt != RW'(0));
        hit_rd     = wb_valid && (wb_rd == bus.in_rd) && (bus.in_rd != RW'(0));
        avail_rs   = !busy[bus.in_rs] || (BYPASS && hit_rs);
        avail_rt   = !busy[bus.in_rt] || (BYPASS && hit_rt);
        dst_wr     = bus.in_wen && (bus.in_rd != RW'(0));
        waw_ok     = !dst_wr || !busy[bus.in_rd] || hit_rd;
        in_ready_c = avail_rs && avail_rt && waw_ok && (!out_valid_q || bus.out_ready);
        issue      = bus.in_valid && in_ready_c;
        opnd_a     = (BYPASS && hit_rs) ? wb_data : read_data_p1;
        opnd_b     = (BYPASS && hit_rt) ? wb_data : read_data_p2;

        busy_nxt = busy;
        if (regwrite) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (issue && dst_wr) begin
            busy_nxt[bus.in_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            busy        <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
            out_wen_q   <= 1'b0;
            wb_err      <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (issue) begin
                out_valid_q <= 1'b1;
                out_a_q     <= opnd_a;
                out_b_q     <= opnd_b;
                out_rd_q    <= bus.in_rd;
                out_wen_q   <= bus.in_wen;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            // Sticky: a result arrived for a register nobody was waiting on.
            if (regwrite && !busy[wb_rd]) begin
                wb_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register file models, scoreboard for BYPASS=1, directed BYPASS=0 case.
module tb_operand_fetch;
    logic reg_clk;
    logic reg_rst;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // BYPASS=1 instance
    operand_fetch_if bus1();
    logic [4:0]  rd1_a1, rd1_a2, wr1_a;
    logic [31:0] rd1_d1, rd1_d2, wr1_d, wb1_data;
    logic        regwrite1, wb1_valid, wb_err1;
    logic [4:0]  wb1_rd;
    logic [31:0] rf1 [32];

    // BYPASS=0 instance
    operand_fetch_if bus0();
    logic [4:0]  rd0_a1, rd0_a2, wr0_a;
    logic [31:0] rd0_d1, rd0_d2, wr0_d, wb0_data;
    logic        regwrite0, wb0_valid, wb_err0;
    logic [4:0]  wb0_rd;
    logic [31:0] rf0 [32];

    operand_fetch #(.BYPASS(1'b1)) dut1 (
        .reg_clk(reg_clk), .reg_rst(reg_rst), .bus(bus1.slave),
        .read_1(rd1_a1), .read_2(rd1_a2), .read_data_p1(rd1_d1), .read_data_p2(rd1_d2),
        .regwrite(regwrite1), .write_3(wr1_a), .write_data_p3(wr1_d),
        .wb_valid(wb1_valid), .wb_rd(wb1_rd), .wb_data(wb1_data), .wb_err(wb_err1)
    );

    operand_fetch #(.BYPASS(1'b0)) dut0 (
        .reg_clk(reg_clk), .reg_rst(reg_rst), .bus(bus0.slave),
        .read_1(rd0_a1), .read_2(rd0_a2), .read_data_p1(rd0_d1), .read_data_p2(rd0_d2),
        .regwrite(regwrite0), .write_3(wr0_a), .write_data_p3(wr0_d),
        .wb_valid(wb0_valid), .wb_rd(wb0_rd), .wb_data(wb0_data), .wb_err(wb_err0)
    );

    initial reg_clk = 1'b0;
    always #5 reg_clk = ~reg_clk;

    // Register files: synchronous write, combinational read, r0 hardwired to zero.
    always @(posedge reg_clk) begin
        if (regwrite1) rf1[wr1_a] <= wr1_d;
        if (regwrite0) rf0[wr0_a] <= wr0_d;
    end
    assign rd1_d1 = (rd1_a1 == 5'd0) ? 32'd0 : rf1[rd1_a1];
    assign rd1_d2 = (rd1_a2 == 5'd0) ? 32'd0 : rf1[rd1_a2];
    assign rd0_d1 = (rd0_a1 == 5'd0) ? 32'd0 : rf0[rd0_a1];
    assign rd0_d2 = (rd0_a2 == 5'd0) ? 32'd0 : rf0[rd0_a2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge reg_clk);
        #1;
    endtask

    // Present an instruction, wait (bounded) for acceptance, push the expected bundle.
    task automatic do_issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic wen, input logic [31:0] ea, input logic [31:0] eb);
        int n;
        exp_t e;
        bus1.in_rs = rs; bus1.in_rt = rt; bus1.in_rd = rd; bus1.in_wen = wen;
        bus1.in_valid = 1'b1;
        #1;
        n = 0;
        while (!bus1.in_ready && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!bus1.in_ready) begin
            errors++;
            $display("FAIL issue_timeout rs=%0d rd=%0d in_ready stayed 0, required 1", rs, rd);
        end else begin
            e.a = ea; e.b = eb; e.rd = rd; e.wen = wen;
            sb.push_back(e);
        end
        step();
        bus1.in_valid = 1'b0;
        #1;
        chk("issue_latency", 32'(bus1.out_valid), 32'd1);
    endtask

    // Scoreboard monitor: every consumed bundle must match the oldest expectation.
    always @(negedge reg_clk) begin
        if (!reg_rst && bus1.out_valid && bus1.out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_bundle", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_out_a", bus1.out_a, e.a);
                chk("sb_out_b", bus1.out_b, e.b);
                chk("sb_out_rd", 32'(bus1.out_rd), 32'(e.rd));
                chk("sb_out_wen", 32'(bus1.out_wen), 32'(e.wen));
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf1[i] = 32'd0;
            rf0[i] = 32'd0;
        end
        reg_rst = 1'b1;
        bus1.in_valid = 0; bus1.in_rs = 0; bus1.in_rt = 0; bus1.in_rd = 0; bus1.in_wen = 0;
        bus1.out_ready = 1'b1;
        bus0.in_valid = 0; bus0.in_rs = 0; bus0.in_rt = 0; bus0.in_rd = 0; bus0.in_wen = 0;
        bus0.out_ready = 1'b1;
        wb1_valid = 0; wb1_rd = 0; wb1_data = 0;
        wb0_valid = 0; wb0_rd = 0; wb0_data = 0;
        step();
        step();
        reg_rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_out_a", bus1.out_a, 32'd0);
        chk("rst_out_b", bus1.out_b, 32'd0);
        chk("rst_out_rd", 32'(bus1.out_rd), 32'd0);
        chk("rst_out_wen", 32'(bus1.out_wen), 32'd0);
        chk("rst_wb_err", 32'(wb_err1), 32'd0);
        chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);

        // BYPASS=0: dependent instruction waits one cycle past the writeback.
        bus0.in_rd = 5'd8; bus0.in_wen = 1'b1; bus0.in_valid = 1'b1;
        #1;
        chk("nb_issue_a", 32'(bus0.in_ready), 32'd1);
        step();
        bus0.in_rs = 5'd8; bus0.in_rd = 5'd0; bus0.in_wen = 1'b0;
        #1;
        chk("nb_raw_block", 32'(bus0.in_ready), 32'd0);
        step();
        wb0_valid = 1'b1; wb0_rd = 5'd8; wb0_data = 32'hCAFE;
        #1;
        chk("nb_no_bypass", 32'(bus0.in_ready), 32'd0);
        step();
        wb0_valid = 1'b0;
        #1;
        chk("nb_ready_after_wb", 32'(bus0.in_ready), 32'd1);
        step();
        bus0.in_valid = 1'b0;
        #1;
        chk("nb_out_valid", 32'(bus0.out_valid), 32'd1);
        chk("nb_out_a", bus0.out_a, 32'hCAFE);

        // r5 = 0x1234 via an owned writeback, then read it back through the file.
        do_issue(5'd0, 5'd0, 5'd5, 1'b1, 32'd0, 32'd0);
        wb1_valid = 1'b1; wb1_rd = 5'd5; wb1_data = 32'h1234;
        #1;
        chk("wb5_regwrite", 32'(regwrite1), 32'd1);
        chk("wb5_write_3", 32'(wr1_a), 32'd5);
        chk("wb5_write_data", wr1_d, 32'h1234);
        step();
        wb1_valid = 1'b0;
        do_issue(5'd5, 5'd0, 5'd0, 1'b0, 32'h1234, 32'd0);

        // RAW on r8 resolved by same-cycle bypass.
        do_issue(5'd0, 5'd0, 5'd8, 1'b1, 32'd0, 32'd0);
        bus1.in_rs = 5'd8; bus1.in_rt = 5'd0; bus1.in_rd = 5'd0; bus1.in_wen = 1'b0;
        bus1.in_valid = 1'b1;
        #1;
        chk("raw_block", 32'(bus1.in_ready), 32'd0);
        step();
        wb1_valid = 1'b1; wb1_rd = 5'd8; wb1_data = 32'hCAFE;
        #1;
        chk("bypass_ready", 32'(bus1.in_ready), 32'd1);
        sb.push_back('{a: 32'hCAFE, b: 32'd0, rd: 5'd0, wen: 1'b0});
        step();
        wb1_valid = 1'b0; bus1.in_valid = 1'b0;

        // Same-cycle clear and set of r9: set wins.
        do_issue(5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 32'd0);
        wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h99;
        bus1.in_rs = 5'd0; bus1.in_rt = 5'd0; bus1.in_rd = 5'd9; bus1.in_wen = 1'b1;
        bus1.in_valid = 1'b1;
        #1;
        chk("waw_hit_ready", 32'(bus1.in_ready), 32'd1);
        chk("r9_regwrite", 32'(regwrite1), 32'd1);
        chk("r9_write_3", 32'(wr1_a), 32'd9);
        sb.push_back('{a: 32'd0, b: 32'd0, rd: 5'd9, wen: 1'b1});
        step();
        wb1_valid = 1'b0; bus1.in_valid = 1'b0;
        bus1.in_rs = 5'd9; bus1.in_wen = 1'b0; bus1.in_rd = 5'd0;
        #1;
        chk("r9_still_busy", 32'(bus1.in_ready), 32'd0);
        wb1_valid = 1'b1; wb1_rd = 5'd9; wb1_data = 32'h77;
        step();
        wb1_valid = 1'b0;
        do_issue(5'd9, 5'd0, 5'd0, 1'b0, 32'h77, 32'd0);
        step();

        // Backpressure: bundle X stalls, Y waits, released after 3 cycles.
        bus1.out_ready = 1'b0;
        do_issue(5'd5, 5'd0, 5'd0, 1'b0, 32'h1234, 32'd0);
        bus1.in_rs = 5'd9; bus1.in_rt = 5'd5; bus1.in_rd = 5'd0; bus1.in_wen = 1'b0;
        bus1.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(bus1.in_ready), 32'd0);
            chk("bp_hold_valid", 32'(bus1.out_valid), 32'd1);
            chk("bp_hold_a", bus1.out_a, 32'h1234);
            chk("bp_hold_b", bus1.out_b, 32'd0);
            step();
            #1;
        end
        bus1.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(bus1.in_ready), 32'd1);
        sb.push_back('{a: 32'h77, b: 32'h1234, rd: 5'd0, wen: 1'b0});
        step();
        bus1.in_valid = 1'b0;
        #1;
        chk("bp_next_a", bus1.out_a, 32'h77);
        chk("bp_next_b", bus1.out_b, 32'h1234);

        // Writeback to r0 is dropped; writeback to idle r3 raises sticky wb_err.
        step();
        wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'hDEAD;
        #1;
        chk("r0_regwrite", 32'(regwrite1), 32'd0);
        step();
        wb1_valid = 1'b0;
        #1;
        chk("r0_no_err", 32'(wb_err1), 32'd0);
        wb1_valid = 1'b1; wb1_rd = 5'd3; wb1_data = 32'h33;
        step();
        wb1_valid = 1'b0;
        #1;
        chk("r3_wb_err", 32'(wb_err1), 32'd1);
        step();
        step();
        step();
        chk("wb_err_sticky", 32'(wb_err1), 32'd1);

        // Reset mid-flight discards the bundle and clears the scoreboard.
        bus1.out_ready = 1'b0;
        do_issue(5'd0, 5'd0, 5'd4, 1'b1, 32'd0, 32'd0);
        reg_rst = 1'b1;
        step();
        reg_rst = 1'b0;
        sb.delete();
        bus1.in_rs = 5'd4; bus1.in_rt = 5'd3; bus1.in_rd = 5'd0; bus1.in_wen = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus1.out_valid), 32'd0);
        chk("mid_rst_r4_free", 32'(bus1.in_ready), 32'd1);
        chk("mid_rst_wb_err", 32'(wb_err1), 32'd0);
        bus1.out_ready = 1'b1;
        do_issue(5'd4, 5'd3, 5'd0, 1'b0, 32'd0, 32'h33);
        step();
        step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
